riscv_if_prefetch: RTL

- Instruction prefetch queue directly upstream of the instruction-fetch stage.
- Takes the requested program counter (if_nxt_pc) from the fetch stage and issues pipelined 32-bit fetches on the instruction memory bus.
- Buffers in-order responses in a small FIFO and presents them as parcels (if_parcel, if_parcel_pc, if_parcel_valid, fault flags).
- Drops stale responses after a flush.

---
 rtl/riscv_state_pkg.sv | 29 ++
 rtl/riscv_if_prefetch_fifo.sv | 58 +++++
 rtl/riscv_if_prefetch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_state_pkg.sv
// Shared pipeline state definitions: exception causes, fetch fault flags and
// the instruction prefetch queue entry layout.
package riscv_state_pkg;

  localparam int XLEN_PKG   = 32;
  localparam int PARCEL_PKG = 32;

  // Synchronous exception causes raised by the front end and decode.
  typedef enum logic [3:0] {
    CAUSE_MISALIGNED_INSTRUCTION   = 4'd0,
    CAUSE_INSTRUCTION_ACCESS_FAULT = 4'd1,
    CAUSE_ILLEGAL_INSTRUCTION      = 4'd2,
    CAUSE_BREAKPOINT               = 4'd3,
    CAUSE_INSTRUCTION_PAGE_FAULT   = 4'd12
  } exception_cause_t;

  // Fault flag bit positions inside a packed if_entry_t (LSBs of the struct).
  localparam int IF_FLT_PAGE_FAULT_BIT = 0;
  localparam int IF_FLT_MISALIGNED_BIT = 1;

  // One prefetch queue entry; the fault flags sit at the positions above.
  typedef struct packed {
    logic [PARCEL_PKG-1:0] data;
    logic [XLEN_PKG-1:0]   pc;
    logic                  misaligned;
    logic                  page_fault;
  } if_entry_t;

endpackage

// File: rtl/riscv_if_prefetch_fifo.sv
// Generic synchronous FIFO with synchronous clear, occupancy count and
// simultaneous push/pop (also when full). A push into a full FIFO without a
// matching pop and a pop from an empty FIFO are ignored. DEPTH must be a
// power of two so the pointers wrap naturally.
module riscv_if_prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  // Pointer and count bookkeeping; clear wins over a concurrent push/pop.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (!rstn || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; r_count alone says which slots hold live data.
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/riscv_if_prefetch.sv
// Instruction prefetch queue in front of the fetch stage. Issues pipelined
// 32-bit fetches for if_nxt_pc, keeps the request PCs in a side queue, buffers
// in-order responses as parcels and drops responses that were in flight when
// the pipeline flushed.
module riscv_if_prefetch
  import riscv_state_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [XLEN-1:0]            if_nxt_pc,
  input  logic                       if_stall,
  input  logic                       if_flush,
  output logic                       if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]     if_parcel,
  output logic [XLEN-1:0]            if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0]  if_parcel_valid,
  output logic                       if_parcel_misaligned,
  output logic                       if_parcel_page_fault,
  output logic                       mem_req,
  output logic [XLEN-1:0]            mem_adr,
  input  logic                       mem_gnt,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_ent_cnt;
  logic [CW-1:0]   w_side_cnt;
  logic [CW:0]     w_occupancy;
  logic [XLEN-1:0] w_side_pc;
  if_entry_t       w_head;
  if_entry_t       w_push_entry;
  logic            w_ent_empty;
  logic            w_aligned;
  logic            w_credit;
  logic            w_accept;
  logic            w_mis_push;
  logic            w_ack_live;
  logic            w_ack_drop;
  logic            w_pop;

  assign w_ent_empty = (w_ent_cnt == '0);
  assign w_aligned   = (if_nxt_pc[1:0] == 2'b00);
  assign w_pop       = rstn & ~w_ent_empty & ~if_stall & ~if_flush;

  // The side queue holds one PC per request still awaiting its response
  // (outstanding + discard). A slot freed by this cycle's pop may be granted
  // again now: the earliest response lands one cycle later.
  assign w_occupancy = {1'b0, w_side_cnt} + {1'b0, w_ent_cnt} - {{CW{1'b0}}, w_pop};
  assign w_credit    = (w_occupancy < (CW+1)'(DEPTH));

  assign mem_req  = rstn & ~if_flush & w_credit & w_aligned;
  assign mem_adr  = rstn ? if_nxt_pc : '0;
  assign w_accept = mem_req & mem_gnt;

  // A misaligned PC waits for all live responses so it lands in program order.
  assign w_mis_push      = rstn & ~w_aligned & (r_outst == '0) & w_credit & ~if_flush;
  assign if_stall_nxt_pc = ~(w_accept | w_mis_push);

  assign w_ack_live = rstn & mem_ack & ~if_flush & (r_discard == '0);
  assign w_ack_drop = rstn & mem_ack & ~if_flush & (r_discard != '0);

  // Select what gets written into the entry FIFO this cycle.
  always_comb begin
    // NOTE: default assigned first so every path drives w_push_entry and no latch is inferred.
    w_push_entry = '0;
    if (w_ack_live) begin
      w_push_entry.data       = mem_rdata;
      w_push_entry.pc         = w_side_pc;
      w_push_entry.page_fault = mem_err;
    end else if (w_mis_push) begin
      w_push_entry.pc         = if_nxt_pc;
      w_push_entry.misaligned = 1'b1;
    end
  end

  // Live/discard response counters; a flush turns everything in flight into discards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else if (if_flush) begin
      r_outst   <= '0;
      r_discard <= r_outst + r_discard - CW'(mem_ack);
    end else begin
      r_outst   <= r_outst + CW'(w_accept) - CW'(w_ack_live);
      r_discard <= r_discard - CW'(w_ack_drop);
    end
  end

  // Parcel buffer presented to the fetch stage.
  riscv_if_prefetch_fifo #(
    .WIDTH ($bits(if_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (if_flush),
    .i_push  (w_ack_live | w_mis_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_count (w_ent_cnt)
  );

  // Request PCs awaiting responses; kept across a flush so stale acks still pop it.
  riscv_if_prefetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (1'b0),
    .i_push  (w_accept),
    .i_pop   (rstn & mem_ack),
    .i_wdata (if_nxt_pc),
    .o_rdata (w_side_pc),
    .o_count (w_side_cnt)
  );

  assign if_parcel_valid      = {(PARCEL_SIZE/16){rstn & ~w_ent_empty}};
  assign if_parcel            = rstn ? w_head.data : '0;
  assign if_parcel_pc         = rstn ? w_head.pc : '0;
  assign if_parcel_misaligned = rstn & w_head[IF_FLT_MISALIGNED_BIT];
  assign if_parcel_page_fault = rstn & w_head[IF_FLT_PAGE_FAULT_BIT];

endmodule
